branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline.
- In IF, predicts direction and target from a direct-mapped BTB with 2-bit saturating counters.
- In EX, compares the branch-decision result (br) against the carried prediction and updates the table.
- On a mispredict, drives the flush and redirect signals to the hazard unit and PC mux.

Parameters:
- IDX_W, 6, BTB index bits; entries = 2**IDX_W.
- TAG_W, 32-IDX_W-2, tag bits taken from pc[31:IDX_W+2].

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc_if  in  32  fetch PC.
- pred_taken  out  1  IF prediction: taken.
- pred_target  out  32  IF predicted target; equals pc_if+4 when not taken.
- stall  in  1  pipeline stall; blocks table update and redirect.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch (br_type != NOBRANCH).
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed branch target.
- ex_br  in  1  actual outcome from branch decision.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  32  predicted target carried down the pipe.
- redirect  out  1  mispredict; flush IF/ID and ID/EX, load redirect_pc.
- redirect_pc  out  32  correct next PC.

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[32], ctr[2].
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Reset (async, rst_n=0): all valid=0 and all ctr=WNT. redirect=0 and pred_taken=0 while reset is asserted.
- Lookup is combinational and takes 0 cycles:
  - idx = pc_if[IDX_W+1:2].
  - hit = valid[idx] && tag[idx]==pc_if[31:IDX_W+2].
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pc_if+4 (32-bit, wraps).
- Update fires only when upd = ex_valid && ex_is_branch && !stall, and is written on the rising clk edge:
  - Hit and ex_br=1: ctr saturating-increments (ST stays ST). target <= ex_target.
  - Hit and ex_br=0: ctr saturating-decrements (SNT stays SNT).
  - Miss and ex_br=1: allocate the entry. valid=1, tag, target=ex_target, ctr=WT. Any conflicting entry is overwritten.
  - Miss and ex_br=0: no write.
- Mispredict, combinational in the EX cycle:
  - mis = upd && ((ex_br != ex_pred_taken) || (ex_br && ex_pred_target != ex_target)).
  - redirect = mis.
  - redirect_pc = ex_br ? ex_target : ex_pc+4.
  - When redirect=0, redirect_pc = ex_pc+4 (don't-care, but held deterministic).
- Simultaneous lookup and update to the same idx: lookup returns the pre-update (old) contents. No bypass.
- stall=1: no table write and redirect=0. The EX inputs stay stable, so the update is re-evaluated in the next unstalled cycle.
- Non-branch or ex_valid=0: no write, redirect=0.
- Reset mid-operation clears the table immediately. The first post-reset fetch predicts not-taken.

Optional Feature:
- BP_STATS_EN: adds outputs stat_branches[31:0] and stat_mispred[31:0].
  - Both reset to 0.
  - stat_branches increments on every upd; stat_mispred increments on every mis.
  - Both wrap at 2**32.
- Without the macro, neither port nor counter exists.

Decomposition:
- Counter encodings (SNT/WNT/WT/ST) go as `define constants in the shared Parameters.v, alongside the existing branch-type defines.
- One sub-module, btb_table: storage, async clear, combinational read port, single synchronous write port.
- Counter update and mispredict logic stay in the top module.

Test Plan:
- Reset, then pc_if=0x100 -> pred_taken=0, pred_target=0x104.
- EX branch at 0x100, ex_br=1, target 0x80, pred not-taken -> redirect=1, redirect_pc=0x80. Next cycle pc_if=0x100 -> pred_taken=1, pred_target=0x80 (ctr=WT).
- Same branch resolves not-taken twice:
  - First -> redirect=1, redirect_pc=0x104, ctr=WNT.
  - Second (pred not-taken) -> redirect=0, ctr=SNT.
- Correctly predicted taken branch with a changed target (ex_target=0x90, ex_pred_target=0x80) -> redirect=1, redirect_pc=0x90, target updated.
- Alias: branch 0x100 allocated, then taken branch 0x200 with the same idx (IDX_W=6) -> entry overwritten. Lookup at 0x100 misses.
- Update with stall=1 -> no redirect, table unchanged. Assert rst_n low mid-run -> all predictions not-taken, redirect=0.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding and its saturating step.
// Purely combinational helpers; no state, no handshake.
// Optional build macro used elsewhere: BP_STATS_EN.
package branch_predict_ctrl_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (IF, EX), one synchronous write port.
// Latency: reads 0 cycles, writes visible the cycle after wr_en; async clear on rst_n; no backpressure.
module btb_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   if_idx,
  output logic               if_valid,
  output logic [TAG_W-1:0]   if_tag,
  output logic [31:0]        if_target,
  output logic [1:0]         if_ctr,
  input  logic [IDX_W-1:0]   ex_idx,
  output logic               ex_valid,
  output logic [TAG_W-1:0]   ex_tag,
  output logic [31:0]        ex_target,
  output logic [1:0]         ex_ctr,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_target,
  input  logic [1:0]         wr_ctr
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  // Reads see pre-write contents when an index is written in the same cycle.
  assign if_valid  = valid_q[if_idx];
  assign if_tag    = tag_q[if_idx];
  assign if_target = target_q[if_idx];
  assign if_ctr    = ctr_q[if_idx];

  assign ex_valid  = valid_q[ex_idx];
  assign ex_tag    = tag_q[ex_idx];
  assign ex_target = target_q[ex_idx];
  assign ex_ctr    = ctr_q[ex_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor (BTB + 2-bit counters) with EX-stage mispredict redirect; BP_STATS_EN adds counters.
// Latency: prediction and redirect are combinational; table update lands on the next clk edge.
// Backpressure: stall suppresses both the update and the redirect; EX inputs are re-evaluated once unstalled.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_br,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_pc_tag, ex_pc_tag;

  logic             if_ent_valid, ex_ent_valid;
  logic [TAG_W-1:0] if_ent_tag, ex_ent_tag;
  logic [31:0]      if_ent_target, ex_ent_target;
  logic [1:0]       if_ent_ctr, ex_ent_ctr;

  logic             if_hit, ex_hit;
  logic             upd, mis;
  logic [31:0]      if_seq_pc, ex_seq_pc;

  logic             wr_en;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  assign if_idx    = pc_if[IDX_W+1:2];
  assign if_pc_tag = pc_if[31:IDX_W+2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_pc_tag = ex_pc[31:IDX_W+2];
  assign if_seq_pc = pc_if + 32'd4;
  assign ex_seq_pc = ex_pc + 32'd4;

  btb_table #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_idx    (if_idx),
    .if_valid  (if_ent_valid),
    .if_tag    (if_ent_tag),
    .if_target (if_ent_target),
    .if_ctr    (if_ent_ctr),
    .ex_idx    (ex_idx),
    .ex_valid  (ex_ent_valid),
    .ex_tag    (ex_ent_tag),
    .ex_target (ex_ent_target),
    .ex_ctr    (ex_ent_ctr),
    .wr_en     (wr_en),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_pc_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // IF lookup
  assign if_hit      = if_ent_valid && (if_ent_tag == if_pc_tag);
  assign pred_taken  = if_hit && ((if_ent_ctr == WT) || (if_ent_ctr == ST));
  assign pred_target = pred_taken ? if_ent_target : if_seq_pc;

  // EX resolution; rst_n gating keeps redirect low throughout reset.
  assign ex_hit = ex_ent_valid && (ex_ent_tag == ex_pc_tag);
  assign upd    = rst_n && ex_valid && ex_is_branch && !stall;
  assign mis    = upd && ((ex_br != ex_pred_taken) ||
                          (ex_br && (ex_pred_target != ex_target)));

  assign redirect    = mis;
  assign redirect_pc = (mis && ex_br) ? ex_target : ex_seq_pc;

  always_comb begin
    wr_en     = 1'b0;
    wr_target = ex_target;
    wr_ctr    = WT;
    if (upd) begin
      if (ex_hit) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_next(ctr_e'(ex_ent_ctr), ex_br);
        if (!ex_br) wr_target = ex_ent_target;
      end else if (ex_br) begin
        wr_en = 1'b1;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd) stat_branches <= stat_branches + 32'd1;
      if (mis) stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed vector bench for branch_predict_ctrl: one table record per cycle, plus reset sequences.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_br;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  branch_predict_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_if          (pc_if),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_br          (ex_br),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        exv;
    logic        exb;
    logic        stl;
    logic [31:0] expc;
    logic [31:0] extgt;
    logic        br;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_tgt;
    logic        e_red;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pc_if          = v.pc;
    ex_valid       = v.exv;
    ex_is_branch   = v.exb;
    stall          = v.stl;
    ex_pc          = v.expc;
    ex_target      = v.extgt;
    ex_br          = v.br;
    ex_pred_taken  = v.ptk;
    ex_pred_target = v.ptgt;
  endtask

  initial begin
    // pc, exv, exb, stall, ex_pc, ex_tgt, br, ptk, ptgt | pt, ptgt, red, rpc
    vecs.push_back('{32'h100, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   0, 32'h104, 0, 32'h4});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  1,0, 32'h104, 0, 32'h104, 1, 32'h80});
    vecs.push_back('{32'h100, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   1, 32'h80,  0, 32'h4});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  0,1, 32'h80,  1, 32'h80,  1, 32'h104});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  0,0, 32'h104, 0, 32'h104, 0, 32'h104});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  0,0, 32'h104, 0, 32'h104, 0, 32'h104});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  1,0, 32'h104, 0, 32'h104, 1, 32'h80});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  1,0, 32'h104, 0, 32'h104, 1, 32'h80});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h80,  1,1, 32'h80,  1, 32'h80,  0, 32'h104});
    vecs.push_back('{32'h100, 1,1,0, 32'h100, 32'h90,  1,1, 32'h80,  1, 32'h80,  1, 32'h90});
    vecs.push_back('{32'h100, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   1, 32'h90,  0, 32'h4});
    vecs.push_back('{32'h100, 1,1,1, 32'h100, 32'h90,  0,1, 32'h90,  1, 32'h90,  0, 32'h104});
    vecs.push_back('{32'h100, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   1, 32'h90,  0, 32'h4});
    vecs.push_back('{32'h100, 1,0,0, 32'h100, 32'h0,   0,1, 32'h90,  1, 32'h90,  0, 32'h104});
    vecs.push_back('{32'h100, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   1, 32'h90,  0, 32'h4});
    vecs.push_back('{32'h200, 1,1,0, 32'h200, 32'h300, 1,0, 32'h204, 0, 32'h204, 1, 32'h300});
    vecs.push_back('{32'h100, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   0, 32'h104, 0, 32'h4});
    vecs.push_back('{32'h200, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   1, 32'h300, 0, 32'h4});
    vecs.push_back('{32'h140, 1,1,0, 32'h140, 32'h500, 0,0, 32'h144, 0, 32'h144, 0, 32'h144});
    vecs.push_back('{32'h140, 0,0,0, 32'h0,   32'h0,   0,0, 32'h0,   0, 32'h144, 0, 32'h4});
    vecs.push_back('{32'hFFFFFFFC, 0,1,0, 32'hFFFFFFFC, 32'h500, 1,0, 32'h0, 0, 32'h0, 0, 32'h0});

    // Reset held, with a would-be mispredict on the EX inputs.
    rst_n = 1'b0;
    drive('{32'h100, 1,1,0, 32'h100, 32'h80, 1,0, 32'h104, 0,0,0,0});
    #12;
    chk("reset_redirect", {31'd0, redirect}, 32'd0);
    chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h104);
    drive('{32'h100, 0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 0,0,0,0});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
      chk($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_tgt);
      chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_red});
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
    end

    // Mid-run reset: entry 0x200 is WT, an EX mispredict is pending.
    @(posedge clk);
    #1;
    drive('{32'h200, 1,1,0, 32'h400, 32'h480, 1,0, 32'h404, 0,0,0,0});
    #1;
    chk("pre_rst_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
    chk("mid_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_pred_target", pred_target, 32'h204);
    @(posedge clk);
    #1;
    drive('{32'h200, 0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 0,0,0,0});
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("post_rst_pred_target", pred_target, 32'h204);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
